prefix_group_gp_stage: RTL
==========================

Name: prefix_group_gp_stage

Overview:
- Registered front-end stage of the wide adder/subtractor datapath; sits directly upstream of the parallel prefix tree first half.
- Splits operands A and B into GROUP-bit groups and computes, per group:
  - a (generate, propagate) pair in the packed 2-bit format the tree consumes;
  - a carry-select sum pair: the group sum with carry-in 0 and with carry-in 1.
- Results are held in a 2-entry valid/ready skid buffer, so the tree and the downstream carry-select stage see stable registered inputs.

Parameters:
- WIDTH, 256, operand width in bits.
- GROUP, 8, bits per group. WIDTH must be an exact multiple of GROUP.
- TREESIZE, WIDTH/GROUP (32), number of groups. Must be a power of two and at least 2, to match the tree.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  1 = subtract (A + ~B), 0 = add.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat.
- q  output  TREESIZE*2  packed group pairs for the prefix tree.
- sum0  output  WIDTH  per-group sums assuming group carry-in 0.
- sum1  output  WIDTH  per-group sums assuming group carry-in 1.
- cin_eff  output  1  effective carry-in of the beat.

Behaviour:
- Reset: out_valid=0, in_ready=1, q=0, sum0=0, sum1=0, cin_eff=0. Both buffer entries empty.
- Reset asserted mid-transfer discards all held beats immediately; nothing is replayed.
- Operand preparation:
  - b_eff = sub ? ~b : b.
  - cin_eff = cin ^ sub, so sub=1, cin=0 gives A-B.
- Per group k (bits k*GROUP+GROUP-1 : k*GROUP), all (GROUP+1)-bit unsigned arithmetic:
  - s0 = a_k + b_eff_k; s1 = a_k + b_eff_k + 1.
  - sum0 slice = s0[GROUP-1:0]; sum1 slice = s1[GROUP-1:0].
  - g_k = s0[GROUP]; p_k = s1[GROUP] & ~s0[GROUP].
- Group 0 folds the carry-in:
  - g_0 = cin_eff ? s1[GROUP] : s0[GROUP]; p_0 = 0.
  - sum0/sum1 slices for group 0 both equal the cin_eff-selected sum.
- Packing: q[2k+1] = g_k, q[2k] = p_k.
- Handshake and skid buffer:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Latency: a beat accepted at edge N appears at the outputs with out_valid=1 after edge N, i.e. visible in cycle N+1.
  - Main register drives the outputs. The skid register fills only when main is valid, out_ready=0 and an input transfer occurs.
  - in_ready is registered: in_ready = ~skid_full.
  - Simultaneous accept and drain with main full and skid empty: main loads the new beat; skid stays empty.
  - Output transfer with skid full: main loads from skid, skid empties, in_ready returns to 1 on the next cycle.
  - Both entries full and out_ready=0: in_ready=0; outputs and held beats stay unchanged.
- Outputs are stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

Test Plan:
- Reset check. Assert reset mid-stream with both entries full -> out_valid=0 and in_ready=1 immediately (asynchronously); q=0, sum0=0, sum1=0.
- Add, carry chain. a=0x00..00FF, b=0x00..0001, cin=0, sub=0 -> next cycle:
  - q[1:0]=2'b10 (g_0=1, p_0=0);
  - group 1 sum0 slice=0x00, sum1 slice=0x01, q[3:2]=2'b00;
  - sum0[7:0]=0x00.
- All-propagate. a=all-ones, b=0, cin=1, sub=0 -> q[1:0]=2'b10; groups 1..31 have q pair 2'b01 (g=0, p=1); cin_eff=1.
- Subtract. a=5, b=3, cin=0, sub=1 -> cin_eff=1, group 0 sum0 slice=0x02, q[1:0]=2'b10; every upper group has p=1 (0x00+0xFF).
- Back-pressure. Hold out_ready=0 and stream 3 beats X, Y, Z -> X and Y accepted, in_ready=0 from the cycle after Y, Z stalls. Then release out_ready=1 -> X, Y, Z emerge in order on consecutive cycles, each exactly once.
- Throughput. out_ready=1 constantly, in_valid=1 for 10 beats -> 10 outputs on 10 consecutive cycles, 1-cycle latency, in_ready never drops.

Source files
------------

// File: rtl/prefix_group_gp_stage.sv
// Per-group generate/propagate and carry-select sums for the prefix adder tree.
// One-cycle latency; 2-entry skid buffer, in_ready drops only when both entries hold beats.
module prefix_group_gp_stage #(
  parameter int WIDTH    = 256,
  parameter int GROUP    = 8,
  parameter int TREESIZE = WIDTH / GROUP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TREESIZE*2-1:0] q,
  output logic [WIDTH-1:0]      sum0,
  output logic [WIDTH-1:0]      sum1,
  output logic                  cin_eff
);

  typedef struct packed {
    logic [TREESIZE*2-1:0] q;
    logic [WIDTH-1:0]      sum0;
    logic [WIDTH-1:0]      sum1;
    logic                  cin_eff;
  } beat_t;

  logic [WIDTH-1:0]      b_eff;
  logic                  cin_x;
  logic [TREESIZE*2-1:0] q_new;
  logic [WIDTH-1:0]      sum0_new;
  logic [WIDTH-1:0]      sum1_new;
  beat_t                 beat_new;

  assign b_eff = sub ? ~b : b;
  assign cin_x = cin ^ sub;

  genvar k;
  generate
    for (k = 0; k < TREESIZE; k++) begin : g_grp
      logic [GROUP:0] s0;
      logic [GROUP:0] s1;

      assign s0 = {1'b0, a[k*GROUP +: GROUP]} + {1'b0, b_eff[k*GROUP +: GROUP]};
      assign s1 = s0 + {{GROUP{1'b0}}, 1'b1};

      if (k == 0) begin : g_lsb
        // The real carry-in is known here, so group 0 resolves fully and never propagates.
        logic [GROUP:0] sel;
        assign sel                         = cin_x ? s1 : s0;
        assign sum0_new[GROUP-1:0]         = sel[GROUP-1:0];
        assign sum1_new[GROUP-1:0]         = sel[GROUP-1:0];
        assign q_new[1:0]                  = {sel[GROUP], 1'b0};
      end else begin : g_upper
        assign sum0_new[k*GROUP +: GROUP]  = s0[GROUP-1:0];
        assign sum1_new[k*GROUP +: GROUP]  = s1[GROUP-1:0];
        assign q_new[2*k +: 2]             = {s0[GROUP], s1[GROUP] & ~s0[GROUP]};
      end
    end
  endgenerate

  assign beat_new = '{q: q_new, sum0: sum0_new, sum1: sum1_new, cin_eff: cin_x};

  beat_t main_dat;
  beat_t skid_dat;
  logic  main_vld;
  logic  skid_vld;
  logic  in_xfer;

  assign in_ready = ~skid_vld;
  assign in_xfer  = in_valid & ~skid_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (!main_vld || out_ready) begin
      // Main is free this cycle: the older skid beat has priority over a new one.
      if (skid_vld) begin
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= in_xfer;
        if (in_xfer) main_dat <= beat_new;
      end
    end else if (in_xfer) begin
      skid_dat <= beat_new;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid = main_vld;
  assign q         = main_dat.q;
  assign sum0      = main_dat.sum0;
  assign sum1      = main_dat.sum1;
  assign cin_eff   = main_dat.cin_eff;

endmodule
